phase_step_sweep_controller: RTL
================================

Name: phase_step_sweep_controller

Overview:
- Upstream stage of the quarter-wave sine generator. Drives its phase_step input so the test source sweeps across a programmed list of frequencies.
- Each frequency point is held for a fixed dwell time. Per-point and end-of-sweep strobes let the FIR bench capture the filter response at each frequency.

Parameters:
PHASE_STEP_WIDTH, 32, width of phase_step and step_increment; matches the sine generator's phase accumulator
DWELL_WIDTH, 24, width of the dwell_cycles config and the internal dwell counter
POINT_WIDTH, 16, width of step_count and point_index

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  terminate sweep immediately; sampled in any state
start_step  input  PHASE_STEP_WIDTH  phase_step of first point
step_increment  input  PHASE_STEP_WIDTH  added to phase_step between points
step_count  input  POINT_WIDTH  number of points in the sweep
dwell_cycles  input  DWELL_WIDTH  cycles each point is held
phase_step  output  PHASE_STEP_WIDTH  registered, to the sine generator
point_index  output  POINT_WIDTH  registered, index of current point
sweep_active  output  1  high in DWELL
point_done  output  1  high during the final dwell cycle of each point
sweep_done  output  1  one-cycle pulse when the sweep completes normally

Behaviour:
- Single clock. Reset is synchronous and active-low on reset_n, sampled at the rising edge of clock.
- Reset values: state IDLE, phase_step 0, point_index 0, dwell counter 0, sweep_active 0, point_done 0, sweep_done 0.
- States: IDLE, DWELL, DONE.
- IDLE:
  - phase_step = 0, so the sine generator's accumulator freezes.
  - On start=1 and step_count!=0, latch start_step, step_increment, step_count and dwell_cycles (dwell_cycles==0 is latched as 1).
  - Same edge: phase_step<=start_step, point_index<=0, counter<=0, go to DWELL.
  - start with step_count==0 is ignored; the block stays in IDLE.
- DWELL:
  - Counter increments each cycle.
  - point_done = (counter == latched_dwell-1), decoded from registers, same cycle.
  - On a point_done cycle, if point_index == latched_count-1, go to DONE.
  - Otherwise counter<=0, point_index<=point_index+1, phase_step<=phase_step+latched_increment.
- Each point presents its phase_step for exactly latched_dwell consecutive cycles.
- DONE: lasts one cycle. sweep_done=1, phase_step=0, sweep_active=0. Next state is IDLE.
- Latency: start sampled at edge N, so the first phase_step appears in cycle N+1. sweep_done appears in cycle N+1+count*dwell.
- Arithmetic: phase_step addition is modulo 2^PHASE_STEP_WIDTH; wrap-around is silent.
- Config inputs are ignored after latch; changing them mid-sweep has no effect.
- start while in DWELL or DONE is ignored.
- abort=1 in any state: next cycle IDLE, phase_step 0, point_index 0, no point_done and no sweep_done. abort has priority over start and over point completion in the same cycle.
- reset_n low mid-sweep: same as abort, with all outputs taking their reset values.

Optional Feature:
SWEEP_REPEAT_EN
- Defined: after the last point's point_done, no DONE state is entered. Instead phase_step<=latched start_step, point_index<=0, counter<=0, and the block stays in DWELL. sweep_done pulses for one cycle concurrently with the first cycle of each new pass. The sweep ends only via abort or reset.
- Undefined: single-pass behaviour as above.

Test Plan:
- Basic sweep: start_step=0x0100_0000, step_increment=0x0080_0000, step_count=4, dwell_cycles=3, start pulsed at edge 0 -> phase_step is 0x01000000 in cycles 1-3, 0x01800000 in 4-6, 0x02000000 in 7-9, 0x02800000 in 10-12. point_done high in cycles 3, 6, 9, 12. sweep_done and phase_step=0 in cycle 13. IDLE from cycle 14.
- Wrap: start_step=0xFFFF_FF00, step_increment=0x200, step_count=2, dwell_cycles=1 -> phase_step is 0xFFFFFF00 then 0x00000100. sweep_done in cycle 3.
- Degenerate config:
  - step_count=0 with start -> stays IDLE, sweep_active 0.
  - dwell_cycles=0, step_count=2 -> each point held 1 cycle, point_done high every cycle of DWELL.
- Abort and ignored start: abort asserted in cycle 5 of the basic sweep -> cycle 6 has phase_step 0, sweep_active 0, no sweep_done. start asserted during DWELL has no effect on the sequence.
- Reset mid-sweep: reset_n low for one edge in cycle 7 -> all outputs at reset values the next cycle. A subsequent start runs a full, correct sweep.
- SWEEP_REPEAT_EN: basic config -> after cycle 12, phase_step returns to 0x01000000 in cycle 13 with sweep_done=1. Pattern repeats every 12 cycles until abort.

Source files
------------

// File: rtl/phase_step_sweep_controller_if.sv
// phase_step_sweep_controller_if: control, config and output bundle of the sweep controller
// master: drives start/abort/config, observes phase_step, point_index and strobes
// slave:  the controller side
interface phase_step_sweep_controller_if #(
  parameter int PHASE_STEP_WIDTH = 32,
  parameter int DWELL_WIDTH      = 24,
  parameter int POINT_WIDTH      = 16
);
  logic                        start;
  logic                        abort;
  logic [PHASE_STEP_WIDTH-1:0] start_step;
  logic [PHASE_STEP_WIDTH-1:0] step_increment;
  logic [POINT_WIDTH-1:0]      step_count;
  logic [DWELL_WIDTH-1:0]      dwell_cycles;
  logic [PHASE_STEP_WIDTH-1:0] phase_step;
  logic [POINT_WIDTH-1:0]      point_index;
  logic                        sweep_active;
  logic                        point_done;
  logic                        sweep_done;
  modport master (
    output start, abort, start_step, step_increment, step_count, dwell_cycles,
    input  phase_step, point_index, sweep_active, point_done, sweep_done
  );
  modport slave (
    input  start, abort, start_step, step_increment, step_count, dwell_cycles,
    output phase_step, point_index, sweep_active, point_done, sweep_done
  );
endinterface

// File: rtl/phase_step_sweep_controller.sv
// phase_step_sweep_controller: steps the sine generator's phase_step through a programmed frequency list
// Ports: clock, reset_n (sync, active-low); bus (slave) carries start/abort, the sweep config
// and the phase_step/point_index/sweep_active/point_done/sweep_done outputs.
// Build option SWEEP_REPEAT_EN: restart from the first point instead of finishing.
module phase_step_sweep_controller #(
  parameter int PHASE_STEP_WIDTH = 32,
  parameter int DWELL_WIDTH      = 24,
  parameter int POINT_WIDTH      = 16
) (
  input logic clock,
  input logic reset_n,
  phase_step_sweep_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
  state_t                      state_q, state_d;
  logic [PHASE_STEP_WIDTH-1:0] phase_q, phase_d, inc_q, inc_d;
  logic [POINT_WIDTH-1:0]      idx_q, idx_d, count_q, count_d;
  logic [DWELL_WIDTH-1:0]      cnt_q, cnt_d, dwell_q, dwell_d;
  logic                        pd, last;
`ifdef SWEEP_REPEAT_EN
  logic [PHASE_STEP_WIDTH-1:0] first_q, first_d;
  logic                        rep_q, rep_d;
`endif
  assign pd   = state_q == DWELL && cnt_q == dwell_q - DWELL_WIDTH'(1);
  assign last = idx_q == count_q - POINT_WIDTH'(1);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      inc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
`ifdef SWEEP_REPEAT_EN
      first_q <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
`ifdef SWEEP_REPEAT_EN
      first_q <= first_d;
      rep_q   <= rep_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    inc_d   = inc_q;
    idx_d   = idx_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
`ifdef SWEEP_REPEAT_EN
    first_d = first_q;
    rep_d   = 1'b0;
`endif
    if (bus.abort) begin
      state_d = IDLE;
      phase_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && bus.step_count != '0) begin
          state_d = DWELL;
          phase_d = bus.start_step;
          inc_d   = bus.step_increment;
          count_d = bus.step_count;
          dwell_d = bus.dwell_cycles == '0 ? DWELL_WIDTH'(1) : bus.dwell_cycles;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef SWEEP_REPEAT_EN
          first_d = bus.start_step;
`endif
        end
        DWELL: if (pd && last) begin
`ifdef SWEEP_REPEAT_EN
          phase_d = first_q;
          idx_d   = '0;
          cnt_d   = '0;
          rep_d   = 1'b1;
`else
          state_d = DONE;
          phase_d = '0;
`endif
        end else if (pd) begin
          cnt_d   = '0;
          idx_d   = idx_q + POINT_WIDTH'(1);
          phase_d = phase_q + inc_q;
        end else begin
          cnt_d   = cnt_q + DWELL_WIDTH'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign bus.phase_step   = phase_q;
  assign bus.point_index  = idx_q;
  assign bus.sweep_active = state_q == DWELL;
  assign bus.point_done   = pd;
`ifdef SWEEP_REPEAT_EN
  assign bus.sweep_done   = rep_q;
`else
  assign bus.sweep_done   = state_q == DONE;
`endif
endmodule
